// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared constants for the decode/issue stage and the ALU:
//            ALU operation selects, RV32I opcodes, funct3/funct7 values.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // ALU operation selects (shared with the ALU itself)
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_XOR = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_AND = 4'd4;
    localparam logic [3:0] ALU_SLL = 4'd5;
    localparam logic [3:0] ALU_SRL = 4'd6;
    localparam logic [3:0] ALU_SRA = 4'd7;
    localparam logic [3:0] ALU_SLT = 4'd8;

    // Major opcodes handled by this stage
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;

    // funct3 encodings
    localparam logic [2:0] F3_ADD_SUB = 3'd0;
    localparam logic [2:0] F3_SLL     = 3'd1;
    localparam logic [2:0] F3_SLT     = 3'd2;
    localparam logic [2:0] F3_SLTU    = 3'd3;
    localparam logic [2:0] F3_XOR     = 3'd4;
    localparam logic [2:0] F3_SRL_SRA = 3'd5;
    localparam logic [2:0] F3_OR      = 3'd6;
    localparam logic [2:0] F3_AND     = 3'd7;

    // funct7 encodings
    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_sel_decoder.sv
`default_nettype none
// ============================================================================
// Module   : alu_sel_decoder
// Purpose  : Combinational RV32I OP / OP-IMM decoder producing the ALU select,
//            the operand-b source and immediate, and an illegal flag.
// Ports    : instr    in   32    instruction word
//            alu_sel  out  4     ALU operation (ALU_ADD when illegal)
//            b_is_imm out  1     operand b comes from imm instead of rs2
//            imm      out  XLEN  I-type immediate or zero-extended shamt
//            illegal  out  1     encoding not supported by this ALU
// Revision : 1.0 - initial release
// ============================================================================
module alu_sel_decoder
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [3:0]      alu_sel,
    output logic            b_is_imm,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    logic [6:0]      w_opcode;
    logic [2:0]      w_f3;
    logic [6:0]      w_f7;
    logic            w_is_shift;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_shamt;
    logic            w_legal;
    logic [3:0]      w_sel;
    logic            w_unused_rd;

    assign w_opcode    = instr[6:0];
    assign w_f3        = instr[14:12];
    assign w_f7        = instr[31:25];
    assign w_is_shift  = (w_f3 == F3_SLL) || (w_f3 == F3_SRL_SRA);
    assign w_imm_i     = {{(XLEN-12){instr[31]}}, instr[31:20]};
    assign w_imm_shamt = {{(XLEN-5){1'b0}}, instr[24:20]};
    // rd is handled by the issue stage, not here
    assign w_unused_rd = ^instr[11:7];

    always_comb begin
        w_legal  = 1'b0;
        w_sel    = ALU_ADD;
        b_is_imm = 1'b0;
        case (w_opcode)
            OPC_OP: begin
                case (w_f3)
                    F3_ADD_SUB: begin
                        if (w_f7 == F7_BASE) begin
                            w_legal = 1'b1; w_sel = ALU_ADD;
                        end else if (w_f7 == F7_ALT) begin
                            w_legal = 1'b1; w_sel = ALU_SUB;
                        end
                    end
                    F3_SRL_SRA: begin
                        if (w_f7 == F7_BASE) begin
                            w_legal = 1'b1; w_sel = ALU_SRL;
                        end else if (w_f7 == F7_ALT) begin
                            w_legal = 1'b1; w_sel = ALU_SRA;
                        end
                    end
                    F3_SLL: begin w_legal = (w_f7 == F7_BASE); w_sel = ALU_SLL; end
                    F3_SLT: begin w_legal = (w_f7 == F7_BASE); w_sel = ALU_SLT; end
                    F3_XOR: begin w_legal = (w_f7 == F7_BASE); w_sel = ALU_XOR; end
                    F3_OR:  begin w_legal = (w_f7 == F7_BASE); w_sel = ALU_OR;  end
                    F3_AND: begin w_legal = (w_f7 == F7_BASE); w_sel = ALU_AND; end
                    default: w_legal = 1'b0;  // SLTU: no unsigned compare in the ALU
                endcase
            end
            OPC_OPIMM: begin
                b_is_imm = 1'b1;
                case (w_f3)
                    F3_ADD_SUB: begin w_legal = 1'b1; w_sel = ALU_ADD; end
                    F3_SLT:     begin w_legal = 1'b1; w_sel = ALU_SLT; end
                    F3_XOR:     begin w_legal = 1'b1; w_sel = ALU_XOR; end
                    F3_OR:      begin w_legal = 1'b1; w_sel = ALU_OR;  end
                    F3_AND:     begin w_legal = 1'b1; w_sel = ALU_AND; end
                    // Immediate shifts: upper bits of the immediate act as funct7
                    F3_SLL:     begin w_legal = (w_f7 == F7_BASE); w_sel = ALU_SLL; end
                    F3_SRL_SRA: begin
                        if (w_f7 == F7_BASE) begin
                            w_legal = 1'b1; w_sel = ALU_SRL;
                        end else if (w_f7 == F7_ALT) begin
                            w_legal = 1'b1; w_sel = ALU_SRA;
                        end
                    end
                    default: w_legal = 1'b0;  // SLTIU
                endcase
            end
            default: w_legal = 1'b0;
        endcase
    end

    // Illegal encodings always present ALU_ADD so the select stays in range
    assign alu_sel = w_legal ? w_sel : ALU_ADD;
    assign illegal = !w_legal;
    assign imm     = w_is_shift ? w_imm_shamt : w_imm_i;

endmodule : alu_sel_decoder
`default_nettype wire

// File: rtl/alu_decode.sv
`default_nettype none
// ============================================================================
// Module   : alu_decode
// Purpose  : RV32I decode/issue stage feeding the ALU. Reads rs1/rs2 from the
//            register file, decodes OP/OP-IMM and registers the result into a
//            single-entry valid/ready issue register.
// Ports    : clk, rst                 clock, async active-high reset
//            in_valid/in_ready/in_instr  instruction handshake
//            rs1_addr/rs2_addr        combinational regfile read addresses
//            rs1_data/rs2_data        same-cycle regfile read data
//            out_valid/out_ready      issue handshake
//            out_a/out_b/out_alu_sel  ALU operands and operation
//            out_rd/out_rd_we         writeback destination and enable
//            out_illegal              unsupported instruction marker
// Revision : 1.0 - initial release
// ============================================================================
module alu_decode
    import alu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_instr,
    output logic [REG_ADDR_W-1:0] rs1_addr,
    output logic [REG_ADDR_W-1:0] rs2_addr,
    input  logic [XLEN-1:0]       rs1_data,
    input  logic [XLEN-1:0]       rs2_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_a,
    output logic [XLEN-1:0]       out_b,
    output logic [3:0]            out_alu_sel,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic                  out_rd_we,
    output logic                  out_illegal
);

    logic [3:0]            w_alu_sel;
    logic                  w_b_is_imm;
    logic [XLEN-1:0]       w_imm;
    logic                  w_illegal;
    logic [XLEN-1:0]       w_b;
    logic [REG_ADDR_W-1:0] w_rd;
    logic                  w_rd_we;
    logic                  w_in_ready;
    logic                  w_capture;

    logic                  r_valid;
    logic [XLEN-1:0]       r_a;
    logic [XLEN-1:0]       r_b;
    logic [3:0]            r_alu_sel;
    logic [REG_ADDR_W-1:0] r_rd;
    logic                  r_rd_we;
    logic                  r_illegal;

    alu_sel_decoder #(
        .XLEN (XLEN)
    ) u_dec (
        .instr    (in_instr),
        .alu_sel  (w_alu_sel),
        .b_is_imm (w_b_is_imm),
        .imm      (w_imm),
        .illegal  (w_illegal)
    );

    assign rs1_addr   = in_instr[15 +: REG_ADDR_W];
    assign rs2_addr   = in_instr[20 +: REG_ADDR_W];
    assign w_rd       = in_instr[7 +: REG_ADDR_W];
    assign w_rd_we    = !w_illegal && (w_rd != '0);
    assign w_b        = w_b_is_imm ? w_imm : rs2_data;

    // Ready whenever the issue register is empty or is being drained this cycle,
    // which lets a new entry replace a consumed one on the same edge.
    assign w_in_ready = !r_valid || out_ready;
    assign w_capture  = in_valid && w_in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_alu_sel <= ALU_ADD;
            r_rd      <= '0;
            r_rd_we   <= 1'b0;
            r_illegal <= 1'b0;
        end else if (w_capture) begin
            r_valid   <= 1'b1;
            r_a       <= rs1_data;
            r_b       <= w_b;
            r_alu_sel <= w_alu_sel;
            r_rd      <= w_rd;
            r_rd_we   <= w_rd_we;
            r_illegal <= w_illegal;
        end else if (r_valid && out_ready) begin
            // Drain: payload fields hold their last values
            r_valid   <= 1'b0;
        end
    end

    assign in_ready    = w_in_ready;
    assign out_valid   = r_valid;
    assign out_a       = r_a;
    assign out_b       = r_b;
    assign out_alu_sel = r_alu_sel;
    assign out_rd      = r_rd;
    assign out_rd_we   = r_rd_we;
    assign out_illegal = r_illegal;

endmodule : alu_decode
`default_nettype wire
